// File: rtl/clock_divider_bank.sv
// Bank of independent runtime-programmable clock dividers.
// Each channel emits a one-cycle tick per period and a pulse- or square-mode divided output.
module clock_divider_bank #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 23
) (
  input  logic                      clk_in,
  input  logic                      reset_n,
  input  logic                      restart,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*WIDTH-1:0] divisor,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       active
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] shadow_q;
    logic             armed_q;
    logic             mode_q;
    logic             tick_q;
    logic             clk_q;

    logic [WIDTH-1:0] div_k;
    logic [WIDTH-1:0] div_dec;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] half;

    assign div_k     = divisor[k*WIDTH +: WIDTH];
    assign div_dec   = div_k - WIDTH'(1);
    assign count_dec = count_q - WIDTH'(1);
    assign half      = shadow_q >> 1;

    // Arm and terminal share one path: both reload from the live divisor, or park on zero.
    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        count_q  <= '0;
        shadow_q <= '0;
        armed_q  <= 1'b0;
        mode_q   <= 1'b0;
        tick_q   <= 1'b0;
        clk_q    <= 1'b0;
      end else if (restart) begin
        armed_q <= 1'b0;
        tick_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else if (!enable[k]) begin
        tick_q <= 1'b0;
        if (!mode_q) clk_q <= 1'b0;
      end else if (!armed_q || count_q == '0) begin
        if (div_k == '0) begin
          armed_q  <= 1'b0;
          count_q  <= '0;
          shadow_q <= '0;
          tick_q   <= 1'b0;
          clk_q    <= 1'b0;
        end else begin
          shadow_q <= div_k;
          count_q  <= div_dec;
          mode_q   <= mode[k];
          armed_q  <= 1'b1;
          tick_q   <= armed_q;
          clk_q    <= armed_q;
        end
      end else begin
        count_q <= count_dec;
        tick_q  <= 1'b0;
        // Square output stays high while the remaining count covers the first ceil(D/2) cycles.
        clk_q   <= mode_q & clk_q & (count_dec >= half);
      end
    end

    assign tick[k]    = tick_q;
    assign clk_out[k] = clk_q;
    assign active[k]  = armed_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: vector table, directed corner sequences,
// and randomized traffic against a period/position reference model.
module tb_clock_divider_bank;
  localparam int unsigned CH = 2;
  localparam int unsigned W  = 23;

  logic            clk_in = 1'b0;
  logic            reset_n;
  logic            restart;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   mode;
  logic [CH*W-1:0] divisor;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   clk_out;
  logic [CH-1:0]   active;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: period length, position within period, latched mode.
  bit m_armed[CH];
  bit m_started[CH];
  bit m_mode[CH];
  bit m_tick[CH];
  bit m_clk[CH];
  int m_pos[CH];
  int m_per[CH];

  typedef struct {
    logic [CH-1:0] en;
    logic [CH-1:0] md;
    int            d0;
    int            d1;
    logic [CH-1:0] tk;
    logic [CH-1:0] co;
    logic [CH-1:0] ac;
  } vec_t;

  vec_t tbl[8];

  clock_divider_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .restart (restart),
    .enable  (enable),
    .mode    (mode),
    .divisor (divisor),
    .tick    (tick),
    .clk_out (clk_out),
    .active  (active)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_armed[k] = 0; m_started[k] = 0; m_mode[k] = 0;
      m_tick[k] = 0; m_clk[k] = 0; m_pos[k] = 0; m_per[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < CH; k++) begin
      int d;
      d = int'(divisor[k*W +: W]);
      if (restart) begin
        m_armed[k] = 0; m_tick[k] = 0; m_clk[k] = 0;
      end else if (!enable[k]) begin
        m_tick[k] = 0;
        if (!m_mode[k]) m_clk[k] = 0;
      end else if (!m_armed[k]) begin
        m_tick[k] = 0; m_clk[k] = 0;
        if (d != 0) begin
          m_armed[k] = 1; m_per[k] = d; m_pos[k] = 0;
          m_mode[k] = mode[k]; m_started[k] = 0;
        end
      end else begin
        m_pos[k]++;
        if (m_pos[k] == m_per[k]) begin
          if (d == 0) begin
            m_armed[k] = 0; m_tick[k] = 0; m_clk[k] = 0;
          end else begin
            m_per[k] = d; m_pos[k] = 0; m_mode[k] = mode[k];
            m_tick[k] = 1; m_clk[k] = 1; m_started[k] = 1;
          end
        end else begin
          m_tick[k] = 0;
          m_clk[k]  = m_started[k] && m_mode[k] && (m_pos[k] < (m_per[k] + 1) / 2);
        end
      end
    end
  endtask

  task automatic compare_model();
    logic [CH-1:0] et, ec, ea;
    for (int k = 0; k < CH; k++) begin
      et[k] = m_tick[k]; ec[k] = m_clk[k]; ea[k] = m_armed[k];
    end
    check("tick", tick, et);
    check("clk_out", clk_out, ec);
    check("active", active, ea);
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_div(input int k, input int v);
    divisor[k*W +: W] = W'(v);
  endtask

  task automatic wait_tick(input int k, input int budget, output int e);
    e = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (tick[k]) begin
        e = i;
        break;
      end
    end
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    int e;
    int hi;
    int t0[$];
    int t1[$];

    reset_n = 1'b0; restart = 1'b0; enable = '0; mode = '0; divisor = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_tick", tick, '0);
    check("reset_clk_out", clk_out, '0);
    check("reset_active", active, '0);
    @(negedge clk_in);
    reset_n = 1'b1;

    // Vector table: ch0 D=3 square, ch1 D=2 pulse; entry 0 is the arm edge.
    tbl[0] = '{2'b11, 2'b01, 3, 2, 2'b00, 2'b00, 2'b11};
    tbl[1] = '{2'b11, 2'b01, 3, 2, 2'b00, 2'b00, 2'b11};
    tbl[2] = '{2'b11, 2'b01, 3, 2, 2'b10, 2'b10, 2'b11};
    tbl[3] = '{2'b11, 2'b01, 3, 2, 2'b01, 2'b01, 2'b11};
    tbl[4] = '{2'b11, 2'b01, 3, 2, 2'b10, 2'b11, 2'b11};
    tbl[5] = '{2'b11, 2'b01, 3, 2, 2'b00, 2'b00, 2'b11};
    tbl[6] = '{2'b11, 2'b01, 3, 2, 2'b11, 2'b11, 2'b11};
    tbl[7] = '{2'b11, 2'b01, 3, 2, 2'b00, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      enable = tbl[i].en; mode = tbl[i].md;
      set_div(0, tbl[i].d0); set_div(1, tbl[i].d1);
      step();
      check("tbl_tick", tick, tbl[i].tk);
      check("tbl_clk_out", clk_out, tbl[i].co);
      check("tbl_active", active, tbl[i].ac);
    end

    // Pulse mode, D=4 and D=5: tick edges counted from the arm edge.
    do_restart();
    enable = 2'b11; mode = 2'b00; set_div(0, 4); set_div(1, 5);
    step();
    for (int i = 1; i <= 15; i++) begin
      step();
      if (tick[0]) t0.push_back(i);
      if (tick[1]) t1.push_back(i);
    end
    check_int("ch0_tick_count", t0.size(), 3);
    check_int("ch1_tick_count", t1.size(), 3);
    if (t0.size() == 3) begin
      check_int("ch0_tick_a", t0[0], 4); check_int("ch0_tick_b", t0[1], 8); check_int("ch0_tick_c", t0[2], 12);
    end
    if (t1.size() == 3) begin
      check_int("ch1_tick_a", t1[0], 5); check_int("ch1_tick_b", t1[1], 10); check_int("ch1_tick_c", t1[2], 15);
    end

    // Square mode D=6, then divisor 7 written mid-period.
    do_restart();
    enable = 2'b01; mode = 2'b01; set_div(0, 6);
    step();
    run(20);
    set_div(0, 7);
    run(30);
    wait_tick(0, 20, e);
    check_int("sq7_tick_seen", int'(e > 0), 1);
    hi = int'(clk_out[0]);
    for (int i = 0; i < 6; i++) begin
      step();
      hi += int'(clk_out[0]);
    end
    check_int("sq7_high_cycles", hi, 4);

    // Divisor 0 parks; first tick 3 edges after switching to 3.
    do_restart();
    enable = 2'b01; mode = 2'b00; set_div(0, 0);
    run(20);
    check("park_active", active, 2'b00);
    set_div(0, 3);
    step();
    wait_tick(0, 10, e);
    check_int("unpark_latency", e, 3);

    // Divisor 1, square: constant tick/clk_out; enable drop clears tick, holds clk_out.
    do_restart();
    enable = 2'b01; mode = 2'b01; set_div(0, 1);
    step();
    run(4);
    check("div1_tick", tick & 2'b01, 2'b01);
    check("div1_clk", clk_out & 2'b01, 2'b01);
    enable = 2'b00;
    step();
    check("div1_drop_tick", tick & 2'b01, 2'b00);
    check("div1_drop_clk", clk_out & 2'b01, 2'b01);

    // D=10 paused for 5 cycles with 4 counts left: tick delayed by exactly 5.
    do_restart();
    enable = 2'b01; mode = 2'b00; set_div(0, 10);
    step();
    run(5);
    enable = 2'b00;
    run(5);
    enable = 2'b01;
    wait_tick(0, 20, e);
    check_int("pause_resume_latency", e, 5);

    // Restart coinciding with terminal suppresses the tick; re-arm follows.
    do_restart();
    enable = 2'b01; mode = 2'b00; set_div(0, 4);
    step();
    run(3);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_terminal_tick", tick, 2'b00);
    step();
    wait_tick(0, 10, e);
    check_int("rearm_latency", e, 4);

    // Asynchronous reset mid-period.
    run(2);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_tick", tick, '0);
    check("async_clk_out", clk_out, '0);
    check("async_active", active, '0);
    @(negedge clk_in);
    reset_n = 1'b1;
    step();
    wait_tick(0, 10, e);
    check_int("post_reset_latency", e, 4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 9) == 0) set_div(k, int'($urandom_range(1, 9)));
        enable[k] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 7) == 0) mode[k] = ($urandom_range(0, 1) == 1);
      end
      restart = ($urandom_range(0, 49) == 0);
      step();
    end
    restart = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
